mem_req_bridge: RTL and testbench



---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_req_bridge_fifo.sv | 64 ++++++
 rtl/mem_req_bridge.sv | 161 ++++++++++++++++
 tb/tb_mem_req_bridge.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the CPU-side SDRAM request path: bridge FSM states,
// SDRAM address width and the posted-write queue entry layout.
package mem_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int SDRAM_AW   = 25;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DRAIN = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic [SDRAM_AW-1:0]   addr;
    logic [WORD_WIDTH-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/mem_req_bridge_fifo.sv
// Single-clock FIFO used as the posted-write queue. Head is read straight
// from storage (no push-to-pop bypass); push while full is legal with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// CPU load/store front end for the SDRAM controller: posts stores into a
// small queue, orders loads behind them and stalls the core until load data returns.
module mem_req_bridge
  import mem_pkg::*;
#(
  parameter int CPU_AW     = 16,
  parameter int WQ_DEPTH   = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [CPU_AW-1:0]     cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  mc_init_done,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [SDRAM_AW-1:0]   mc_addr,
  output logic [WORD_WIDTH-1:0] mc_wdata,
  input  logic                  mc_ready,
  input  logic                  mc_rvalid,
  input  logic [WORD_WIDTH-1:0] mc_rdata,
  output logic                  rd_err,
  output bridge_state_t         state
);

  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
  localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  if (CPU_AW > SDRAM_AW || CPU_AW < 1) begin : g_aw_check
    $error("CPU_AW must be between 1 and SDRAM_AW");
  end

  bridge_state_t       state_n;
  mem_wr_t             wq_din;
  mem_wr_t             wq_head;
  logic                wq_push;
  logic                wq_pop;
  logic                wq_full;
  logic                wq_empty;
  logic [CNT_W-1:0]    wq_count;
  logic                last_pop;
  logic                wr_present;
  logic                rd_present;
  logic                req_held;
  logic                accept_rd;
  logic                tmo_hit;
  logic [SDRAM_AW-1:0] rd_addr;
  logic [TMO_W-1:0]    tmo_cnt;

  sync_fifo #(
    .WIDTH ($bits(mem_wr_t)),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk   (clk),
    .rst   (rst),
    .push  (wq_push),
    .din   (wq_din),
    .pop   (wq_pop),
    .dout  (wq_head),
    .full  (wq_full),
    .empty (wq_empty),
    .count (wq_count)
  );

  // Controller handshake: mc_req is valid, mc_ready is ready; a beat moves on a
  // clock edge where both are 1, and mc_* stay unchanged while valid waits on ready.
  assign wr_present = (state == IDLE || state == WR_DRAIN) && !wq_empty;
  assign rd_present = (state == RD_ISSUE);
  assign mc_req     = rst && (mc_init_done || req_held) && (wr_present || rd_present);
  assign mc_we      = mc_req && wr_present;
  assign mc_addr    = !mc_req ? '0 : (rd_present ? rd_addr : wq_head.addr);
  assign mc_wdata   = mc_we ? wq_head.data : '0;

  assign wq_pop   = mc_we && mc_ready;
  assign last_pop = wq_pop && (wq_count == CNT_W'(1));

  // A full queue still takes a store when its head leaves in the same cycle.
  assign cpu_stall = !rst || !mc_init_done || (state != IDLE) ||
                     (cpu_req && cpu_we && wq_full && !wq_pop);

  assign wq_din    = {SDRAM_AW'(cpu_addr), cpu_wdata};
  assign wq_push   = cpu_req && cpu_we && !cpu_stall;
  assign accept_rd = cpu_req && !cpu_we && !cpu_stall;

  assign tmo_hit = (RD_TIMEOUT != 0) && (state == RD_WAIT) && !mc_rvalid &&
                   (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept_rd) begin
          state_n = (wq_empty || last_pop) ? RD_ISSUE : WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        if (wq_empty || last_pop) begin
          state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (mc_req && mc_ready) begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mc_rvalid || tmo_hit) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_held   <= 1'b0;
      rd_addr    <= '0;
      tmo_cnt    <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      req_held   <= mc_req && !mc_ready;
      cpu_rvalid <= 1'b0;
      if (accept_rd) begin
        rd_addr <= SDRAM_AW'(cpu_addr);
      end
      if (state == RD_ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == RD_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (state == RD_WAIT) begin
        if (mc_rvalid) begin
          cpu_rdata  <= mc_rdata;
          cpu_rvalid <= 1'b1;
        end else if (tmo_hit) begin
          cpu_rdata  <= '0;
          cpu_rvalid <= 1'b1;
          rd_err     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge: init hold, posted writes, read ordering,
// back-pressure, read timeout and reset in the middle of traffic.
module tb_mem_req_bridge;
  import mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cpu_req = 1'b0;
  logic                  cpu_we = 1'b0;
  logic [15:0]           cpu_addr = '0;
  logic [WORD_WIDTH-1:0] cpu_wdata = '0;
  logic                  cpu_stall;
  logic [WORD_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;
  logic                  mc_init_done = 1'b0;
  logic                  mc_req;
  logic                  mc_we;
  logic [SDRAM_AW-1:0]   mc_addr;
  logic [WORD_WIDTH-1:0] mc_wdata;
  logic                  mc_ready = 1'b0;
  logic                  mc_rvalid = 1'b0;
  logic [WORD_WIDTH-1:0] mc_rdata = '0;
  logic                  rd_err;
  bridge_state_t         state;

  int checks = 0;
  int failures = 0;

  // Every controller beat as {we, addr, data}; data is 0 for reads.
  logic [41:0] log_q[$];
  logic [41:0] exp_q[$];

  int          resp_delay = 3;
  logic        resp_en = 1'b1;
  logic [15:0] resp_data = '0;
  int          pending = 0;

  mem_req_bridge #(.CPU_AW(16), .WQ_DEPTH(4), .RD_TIMEOUT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .mc_init_done (mc_init_done),
    .mc_req       (mc_req),
    .mc_we        (mc_we),
    .mc_addr      (mc_addr),
    .mc_wdata     (mc_wdata),
    .mc_ready     (mc_ready),
    .mc_rvalid    (mc_rvalid),
    .mc_rdata     (mc_rdata),
    .rd_err       (rd_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Controller model: inputs only change at posedge+1, so negedge values are
  // the ones the next posedge will use.
  always @(negedge clk) begin
    if (pending > 0) begin
      pending = pending - 1;
      mc_rvalid = (pending == 0);
      mc_rdata = resp_data;
    end else begin
      mc_rvalid = 1'b0;
    end
    if (rst && mc_req && mc_ready) begin
      log_q.push_back({mc_we, mc_addr, mc_we ? mc_wdata : 16'h0000});
      if (!mc_we && resp_en) pending = resp_delay;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [41:0] ent(input logic we, input logic [24:0] a, input logic [15:0] d);
    return {we, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_store(input logic [15:0] a, input logic [15:0] d, input int max_wait,
                           output int waited);
    bit acc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = !cpu_stall;
      tick();
      if (acc) break;
      waited++;
      if (waited >= max_wait) break;
    end
    cpu_req = 1'b0;
  endtask

  task automatic cpu_load(input logic [15:0] a, input int max_wait, output bit ok);
    bit acc;
    int waited;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    waited = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      acc = !cpu_stall;
      tick();
      if (acc) begin ok = 1'b1; break; end
      waited++;
      if (waited >= max_wait) break;
    end
    cpu_req = 1'b0;
  endtask

  task automatic wait_rvalid(input int max_cycles, output bit got, output logic [15:0] data,
                             output int wait_cycles, output logic stall_at);
    got = 1'b0; data = '0; wait_cycles = 0; stall_at = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (cpu_rvalid) begin
        got = 1'b1; data = cpu_rdata; stall_at = cpu_stall;
        break;
      end
      if (state == RD_WAIT) wait_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mc_init_done = 1'b0; cpu_req = 1'b0; mc_ready = 1'b0;
    tick(); tick();
    checks++;
    if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_stall: got %0b want 1", cpu_stall); end
    checks++;
    if (mc_req !== 1'b0 || mc_we !== 1'b0) begin
      failures++; $display("FAIL rst_mc_req: got req=%0b we=%0b want 0", mc_req, mc_we);
    end
    checks++;
    if (cpu_rvalid !== 1'b0 || rd_err !== 1'b0) begin
      failures++; $display("FAIL rst_flags: got rvalid=%0b err=%0b want 0", cpu_rvalid, rd_err);
    end
    checks++;
    if (mc_addr !== '0 || mc_wdata !== '0 || cpu_rdata !== '0) begin
      failures++;
      $display("FAIL rst_data: got addr=%0h wdata=%0h rdata=%0h want 0", mc_addr, mc_wdata, cpu_rdata);
    end
    checks++;
    if (state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d want %0d", state, IDLE); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_init_hold();
    int bad;
    log_q.delete();
    mc_ready = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 16'h5A5A;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (cpu_stall !== 1'b1 || mc_req !== 1'b0) begin
        failures++; bad++;
        $display("FAIL init_hold cycle %0d: got stall=%0b mc_req=%0b want 1/0", i, cpu_stall, mc_req);
      end
    end
    mc_init_done = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL init_release: got stall=%0b want 0", cpu_stall); end
    tick();
    cpu_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (log_q.size() != 1) begin
      failures++; $display("FAIL init_write_count: got %0d want 1", log_q.size());
    end else begin
      checks++;
      if (log_q[0] !== ent(1'b1, 25'h0000123, 16'h5A5A)) begin
        failures++; $display("FAIL init_write: got %0h want %0h", log_q[0], ent(1'b1, 25'h0000123, 16'h5A5A));
      end
    end
  endtask

  task automatic test_posted_writes();
    int w;
    log_q.delete(); exp_q.delete();
    mc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_store(16'(i), 16'h00A0 + 16'(i), 8, w);
      checks++;
      if (w != 0) begin failures++; $display("FAIL post_nostall store %0d: got %0d stall cycles want 0", i, w); end
      exp_q.push_back(ent(1'b1, 25'(i), 16'h00A0 + 16'(i)));
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0004; cpu_wdata = 16'h00A4;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1) begin failures++; $display("FAIL full_stall: got %0b want 1", cpu_stall); end
    checks++;
    if (mc_req !== 1'b1 || mc_we !== 1'b1 || mc_addr !== 25'h0 || mc_wdata !== 16'h00A0) begin
      failures++;
      $display("FAIL head_present: got req=%0b we=%0b addr=%0h data=%0h want 1/1/0/a0",
               mc_req, mc_we, mc_addr, mc_wdata);
    end
    tick();
    mc_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL full_push_pop: got stall=%0b want 0", cpu_stall); end
    tick();
    cpu_req = 1'b0;
    exp_q.push_back(ent(1'b1, 25'h4, 16'h00A4));
    repeat (8) tick();
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL post_count: got %0d want %0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL post_order beat %0d: got %0h want %0h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_read_ordering();
    int w, wc;
    bit ok, got;
    logic [15:0] d;
    logic st;
    log_q.delete(); exp_q.delete();
    mc_ready = 1'b1; resp_en = 1'b1; resp_delay = 3; resp_data = 16'h00A1;
    cpu_store(16'h0010, 16'h00B0, 8, w);
    cpu_store(16'h0011, 16'h00B1, 8, w);
    cpu_load(16'h0001, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_accept: got 0 want 1"); end
    wait_rvalid(50, got, d, wc, st);
    checks++;
    if (!got || d !== 16'h00A1) begin failures++; $display("FAIL rd_data: got valid=%0b data=%0h want 1/a1", got, d); end
    checks++;
    if (wc != 3) begin failures++; $display("FAIL rd_latency: got %0d RD_WAIT cycles want 3", wc); end
    checks++;
    if (st !== 1'b0) begin failures++; $display("FAIL rd_stall_release: got %0b want 0", st); end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse: got %0b want 0", cpu_rvalid); end
    exp_q.push_back(ent(1'b1, 25'h10, 16'h00B0));
    exp_q.push_back(ent(1'b1, 25'h11, 16'h00B1));
    exp_q.push_back(ent(1'b0, 25'h01, 16'h0000));
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rd_order_count: got %0d want %0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rd_order beat %0d: got %0h want %0h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int idx;
    bit acc, prev_hold;
    logic [SDRAM_AW-1:0]   p_addr;
    logic [WORD_WIDTH-1:0] p_data;
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(1'b1, 25'h20 + 25'(i), 16'h00C0 + 16'(i)));
    idx = 0; prev_hold = 1'b0; p_addr = '0; p_data = '0;
    for (int cyc = 0; cyc < 300 && !(idx == 8 && log_q.size() == 8); cyc++) begin
      mc_ready = 1'($urandom_range(0, 1));
      if (idx < 8) begin
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h0020 + 16'(idx); cpu_wdata = 16'h00C0 + 16'(idx);
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (mc_req !== 1'b1 || mc_we !== 1'b1 || mc_addr !== p_addr || mc_wdata !== p_data) begin
          failures++;
          $display("FAIL bp_hold: got req=%0b addr=%0h data=%0h want 1/%0h/%0h",
                   mc_req, mc_addr, mc_wdata, p_addr, p_data);
        end
      end
      prev_hold = mc_req && !mc_ready;
      p_addr = mc_addr; p_data = mc_wdata;
      acc = cpu_req && !cpu_stall;
      tick();
      if (acc) idx++;
    end
    cpu_req = 1'b0; mc_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (idx != 8 || log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count: got stores=%0d beats=%0d want 8/8", idx, log_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL bp_beat %0d: got %0h want %0h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int wc;
    bit ok, got;
    logic [15:0] d;
    logic st;
    mc_ready = 1'b1; resp_en = 1'b0;
    cpu_load(16'h0005, 20, ok);
    checks++;
    if (!ok || rd_err !== 1'b0) begin failures++; $display("FAIL tmo_start: got ok=%0b err=%0b want 1/0", ok, rd_err); end
    wait_rvalid(400, got, d, wc, st);
    checks++;
    if (!got || d !== 16'h0000) begin failures++; $display("FAIL tmo_data: got valid=%0b data=%0h want 1/0", got, d); end
    checks++;
    if (wc != 255) begin failures++; $display("FAIL tmo_cycles: got %0d want 255", wc); end
    checks++;
    if (rd_err !== 1'b1 || state !== IDLE || st !== 1'b0) begin
      failures++; $display("FAIL tmo_flags: got err=%0b state=%0d stall=%0b want 1/0/0", rd_err, state, st);
    end
    resp_en = 1'b1; resp_delay = 2; resp_data = 16'h7E57;
    cpu_load(16'h0006, 20, ok);
    wait_rvalid(50, got, d, wc, st);
    checks++;
    if (!got || d !== 16'h7E57 || wc != 2) begin
      failures++; $display("FAIL tmo_next_load: got valid=%0b data=%0h wait=%0d want 1/7e57/2", got, d, wc);
    end
    checks++;
    if (rd_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %0b want 1", rd_err); end
  endtask

  task automatic test_reset_mid_op();
    int w, seen;
    bit ok;
    mc_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_store(16'h0030 + 16'(i), 16'h00D0 + 16'(i), 8, w);
    cpu_load(16'h0040, 4, ok);
    checks++;
    if (!ok || state !== WR_DRAIN) begin failures++; $display("FAIL rm_drain: got ok=%0b state=%0d want 1/%0d", ok, state, WR_DRAIN); end
    rst = 1'b0;
    tick();
    checks++;
    if (cpu_stall !== 1'b1 || mc_req !== 1'b0 || cpu_rvalid !== 1'b0 || state !== IDLE || rd_err !== 1'b0) begin
      failures++;
      $display("FAIL rm_outputs: got stall=%0b req=%0b rvalid=%0b state=%0d err=%0b want 1/0/0/0/0",
               cpu_stall, mc_req, cpu_rvalid, state, rd_err);
    end
    rst = 1'b1;
    log_q.delete();
    mc_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (log_q.size() != 0) begin failures++; $display("FAIL rm_discard: got %0d beats want 0", log_q.size()); end
    resp_en = 1'b1; resp_delay = 6; resp_data = 16'hDEAD;
    cpu_load(16'h0041, 4, ok);
    tick();
    checks++;
    if (state !== RD_WAIT) begin failures++; $display("FAIL rm_rdwait: got %0d want %0d", state, RD_WAIT); end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== IDLE || mc_req !== 1'b0 || cpu_stall !== 1'b1) begin
      failures++; $display("FAIL rm_rd_reset: got state=%0d req=%0b stall=%0b want 0/0/1", state, mc_req, cpu_stall);
    end
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_rvalid) seen++;
    end
    checks++;
    if (seen != 0 || state !== IDLE) begin
      failures++; $display("FAIL rm_late_rvalid: got %0d pulses state=%0d want 0/0", seen, state);
    end
  endtask

  initial begin
    test_reset();
    test_init_hold();
    test_posted_writes();
    test_read_ordering();
    test_back_pressure();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
